// File: rtl/csc_sched_pkg.sv
// rtl/csc_sched_pkg.sv - shared state encoding and parameter defaults for csc_frame_sched
package csc_sched_pkg;

    localparam int CSC_CNT_W_DEF    = 12;
    localparam int CSC_PIPE_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/csc_edge_det.sv
// rtl/csc_edge_det.sv - rise/fall pulses of a level against its registered previous sample
module csc_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    // Pulses are valid in the same cycle as the new level so the scheduler can act on that sample.
    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/csc_frame_sched.sv
// rtl/csc_frame_sched.sv - frame gate/scheduler in front of a colour-space converter (optional CSC_SCHED_WINDOW_EN)
module csc_frame_sched
    import csc_sched_pkg::*;
#(
    parameter int PIPE_LAT = CSC_PIPE_LAT_DEF,
    parameter int CNT_W    = CSC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [3:0]       cfg_skip,
`ifdef CSC_SCHED_WINDOW_EN
    input  logic [CNT_W-1:0] cfg_x_start,
    input  logic [CNT_W-1:0] cfg_x_end,
    input  logic [CNT_W-1:0] cfg_y_start,
    input  logic [CNT_W-1:0] cfg_y_end,
`endif
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [7:0]       per_img_red,
    input  logic [7:0]       per_img_green,
    input  logic [7:0]       per_img_blue,
    output logic             csc_frame_vsync,
    output logic             csc_frame_href,
    output logic             csc_frame_clken,
    output logic [7:0]       csc_img_red,
    output logic [7:0]       csc_img_green,
    output logic [7:0]       csc_img_blue,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [15:0]      DRAIN_LAST = (PIPE_LAT > 0) ? 16'(PIPE_LAT - 1) : 16'd0;

    sched_state_t     state_q, state_d;
    logic [3:0]       skip_cnt;
    logic             stop_pending;
    logic [15:0]      drain_cnt;
    logic             done_now;
    logic             fwd;
    logic             in_win;
    logic             v_rise, v_fall, h_rise, h_fall;
    logic [CNT_W-1:0] pix_acc, line_acc, line_inc;

    csc_edge_det u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (per_frame_vsync),
        .rise (v_rise),
        .fall (v_fall)
    );

    csc_edge_det u_href_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (per_frame_href),
        .rise (h_rise),
        .fall (h_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start && !cmd_stop) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (cmd_stop) state_d = ST_IDLE;
                else if (v_rise && skip_cnt == 4'd0) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (v_fall) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    done_now = 1'b1;
                    state_d  = (stop_pending || cmd_stop) ? ST_IDLE : ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The vsync-rise sample that arms a frame is forwarded along with the rest of it.
    assign fwd = (state_q == ST_ACTIVE) || (state_q == ST_ARMED && state_d == ST_ACTIVE);

    assign line_inc = (line_acc == CNT_MAX) ? line_acc : line_acc + CNT_W'(1);

`ifdef CSC_SCHED_WINDOW_EN
    logic [CNT_W-1:0] x_cur, y_cur;
    assign x_cur  = h_rise ? '0 : pix_acc;
    assign y_cur  = v_rise ? '0 : line_acc;
    assign in_win = (x_cur >= cfg_x_start) && (x_cur <= cfg_x_end) &&
                    (y_cur >= cfg_y_start) && (y_cur <= cfg_y_end);
`else
    assign in_win = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt        <= 4'd0;
            stop_pending    <= 1'b0;
            drain_cnt       <= 16'd0;
            frame_done      <= 1'b0;
            frame_cnt       <= 16'd0;
            csc_frame_vsync <= 1'b0;
            csc_frame_href  <= 1'b0;
            csc_frame_clken <= 1'b0;
            csc_img_red     <= 8'd0;
            csc_img_green   <= 8'd0;
            csc_img_blue    <= 8'd0;
            pix_acc         <= '0;
            line_acc        <= '0;
            pix_cnt         <= '0;
            line_cnt        <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_ARMED) begin
                skip_cnt <= 4'd0;
            end else if (state_q == ST_ARMED && v_rise && !cmd_stop) begin
                skip_cnt <= (skip_cnt == 4'd0) ? cfg_skip : skip_cnt - 4'd1;
            end

            if (state_d == ST_IDLE) begin
                stop_pending <= 1'b0;
            end else if (cmd_stop && (state_q == ST_ACTIVE || state_q == ST_DRAIN)) begin
                stop_pending <= 1'b1;
            end

            drain_cnt  <= (state_q == ST_DRAIN) ? drain_cnt + 16'd1 : 16'd0;
            frame_done <= done_now;
            if (done_now) frame_cnt <= frame_cnt + 16'd1;

            csc_frame_vsync <= fwd & per_frame_vsync;
            csc_frame_href  <= fwd & per_frame_href & in_win;
            csc_frame_clken <= fwd & per_frame_clken & in_win;
            csc_img_red     <= fwd ? per_img_red   : 8'd0;
            csc_img_green   <= fwd ? per_img_green : 8'd0;
            csc_img_blue    <= fwd ? per_img_blue  : 8'd0;

            // Counters see every pixel of a forwarded frame, independent of the window.
            if (fwd) begin
                if (h_rise) begin
                    pix_acc <= CNT_W'(per_frame_clken);
                end else if (per_frame_href && per_frame_clken && pix_acc != CNT_MAX) begin
                    pix_acc <= pix_acc + CNT_W'(1);
                end
                if (h_fall) pix_cnt <= pix_acc;

                if (v_rise) begin
                    line_acc <= '0;
                end else if (h_fall) begin
                    line_acc <= line_inc;
                end
                if (v_fall) line_cnt <= h_fall ? line_inc : line_acc;
            end
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_csc_frame_sched.sv
// tb/tb_csc_frame_sched.sv - self-checking bench for csc_frame_sched
module tb_csc_frame_sched;

    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = 12;

    typedef struct {
        int skip;
        int nframes;
        int lines;
        int pix;
        int exp_fc;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_start, cmd_stop;
    logic [3:0]       cfg_skip;
    logic             per_frame_vsync, per_frame_href, per_frame_clken;
    logic [7:0]       per_img_red, per_img_green, per_img_blue;
    logic             csc_frame_vsync, csc_frame_href, csc_frame_clken;
    logic [7:0]       csc_img_red, csc_img_green, csc_img_blue;
    logic             busy, frame_done;
    logic [15:0]      frame_cnt;
    logic [CNT_W-1:0] line_cnt, pix_cnt;
    logic [1:0]       state;
`ifdef CSC_SCHED_WINDOW_EN
    logic [CNT_W-1:0] cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_end;
`endif

    int checks = 0;
    int errors = 0;

    // Frame-level reference: which frames are forwarded and what the counters end at.
    bit m_armed;
    bit m_stop;
    int m_skip_left;
    int m_cfg_skip;
    int m_fc;
    bit cur_fwd;
    int cur_x, cur_y;
    int win_x0, win_x1, win_y0, win_y1;
    int clken_pulses;
    vec_t tbl[4];

    always #5 clk = ~clk;

    csc_frame_sched #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_start       (cmd_start),
        .cmd_stop        (cmd_stop),
        .cfg_skip        (cfg_skip),
`ifdef CSC_SCHED_WINDOW_EN
        .cfg_x_start     (cfg_x_start),
        .cfg_x_end       (cfg_x_end),
        .cfg_y_start     (cfg_y_start),
        .cfg_y_end       (cfg_y_end),
`endif
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_red     (per_img_red),
        .per_img_green   (per_img_green),
        .per_img_blue    (per_img_blue),
        .csc_frame_vsync (csc_frame_vsync),
        .csc_frame_href  (csc_frame_href),
        .csc_frame_clken (csc_frame_clken),
        .csc_img_red     (csc_img_red),
        .csc_img_green   (csc_img_green),
        .csc_img_blue    (csc_img_blue),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_cnt       (frame_cnt),
        .line_cnt        (line_cnt),
        .pix_cnt         (pix_cnt),
        .state           (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [31:0] exp_v;
        logic        win;
        win   = (cur_x >= win_x0 && cur_x <= win_x1 && cur_y >= win_y0 && cur_y <= win_y1);
        exp_v = 32'd0;
        if (cur_fwd && !rst)
            exp_v = {5'd0, per_frame_vsync, per_frame_href & win, per_frame_clken & win,
                     per_img_red, per_img_green, per_img_blue};
        @(posedge clk);
        #1;
        chk("csc_out", {5'd0, csc_frame_vsync, csc_frame_href, csc_frame_clken,
                        csc_img_red, csc_img_green, csc_img_blue}, exp_v);
        if (csc_frame_clken) clken_pulses++;
        per_img_red   = 8'($urandom);
        per_img_green = 8'($urandom);
        per_img_blue  = 8'($urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_lcnt"}, 32'(line_cnt), 32'd0);
        chk({tag, "_pcnt"}, 32'(pix_cnt), 32'd0);
    endtask

    task automatic do_reset();
        cur_fwd = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero_outputs("reset");
        m_armed = 1'b0;
        m_stop  = 1'b0;
        m_fc    = 0;
    endtask

    task automatic start_cmd();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        if (!m_armed) begin
            m_armed     = 1'b1;
            m_skip_left = 0;
        end
        chk("start_state", 32'(state), m_armed ? 32'd1 : 32'd0);
    endtask

    task automatic frame(input int lines, input int pix, input int stop_line, input int rst_line);
        bit fwd;
        fwd = 1'b0;
        if (m_armed) begin
            if (m_skip_left == 0) begin
                fwd         = 1'b1;
                m_skip_left = m_cfg_skip;
            end else begin
                m_skip_left--;
            end
        end
        cur_fwd = fwd;
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        repeat (3) step();
        for (int l = 0; l < lines; l++) begin
            cur_y = l;
            if (l == rst_line) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_zero_outputs("midrst");
                m_armed = 1'b0;
                m_stop  = 1'b0;
                m_fc    = 0;
                fwd     = 1'b0;
                cur_fwd = 1'b0;
            end
            if (l == stop_line) begin
                cmd_stop = 1'b1;
                if (fwd) m_stop = 1'b1;
                else m_armed = 1'b0;
            end
            per_frame_href = 1'b1;
            for (int p = 0; p < pix; p++) begin
                cur_x = p;
                if ($urandom_range(0, 2) == 0) begin
                    per_frame_clken = 1'b0;
                    step();
                    cmd_stop = 1'b0;
                end
                per_frame_clken = 1'b1;
                step();
                cmd_stop = 1'b0;
            end
            per_frame_clken = 1'b0;
            per_frame_href  = 1'b0;
            repeat (2) step();
        end
        per_frame_vsync = 1'b0;
        step();
        cur_fwd = 1'b0;
        if (fwd) chk("drain_entry", 32'(state), 32'd3);
        for (int k = 1; k <= PIPE_LAT + 2; k++) begin
            step();
            chk("frame_done", 32'(frame_done), 32'(fwd && k == PIPE_LAT));
        end
        if (fwd) begin
            m_fc++;
            if (m_stop) begin
                m_armed = 1'b0;
                m_stop  = 1'b0;
            end
            chk("line_cnt", 32'(line_cnt), 32'(lines));
            chk("pix_cnt", 32'(pix_cnt), 32'(pix));
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fc & 16'hFFFF));
        chk("post_state", 32'(state), m_armed ? 32'd1 : 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int nf;
        rst = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cfg_skip = 4'd0;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
        per_img_red = 8'd0; per_img_green = 8'd0; per_img_blue = 8'd0;
        m_armed = 1'b0; m_stop = 1'b0; m_skip_left = 0; m_cfg_skip = 0; m_fc = 0;
        cur_fwd = 1'b0; cur_x = 0; cur_y = 0; clken_pulses = 0;
        win_x0 = 0; win_x1 = 32'h7FFF_FFFF; win_y0 = 0; win_y1 = 32'h7FFF_FFFF;
`ifdef CSC_SCHED_WINDOW_EN
        cfg_x_start = '0; cfg_x_end = '1; cfg_y_start = '0; cfg_y_end = '1;
`endif
        tbl[0] = '{skip: 0, nframes: 1, lines: 4, pix: 8, exp_fc: 1};
        tbl[1] = '{skip: 2, nframes: 6, lines: 4, pix: 8, exp_fc: 2};
        tbl[2] = '{skip: 1, nframes: 5, lines: 2, pix: 3, exp_fc: 3};
        tbl[3] = '{skip: 3, nframes: 4, lines: 3, pix: 6, exp_fc: 1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 4; i++) begin
            do_reset();
            cfg_skip   = 4'(tbl[i].skip);
            m_cfg_skip = tbl[i].skip;
            start_cmd();
            repeat (2) step();
            for (int f = 0; f < tbl[i].nframes; f++) frame(tbl[i].lines, tbl[i].pix, -1, -1);
            chk("tbl_frame_cnt", 32'(frame_cnt), 32'(tbl[i].exp_fc));
        end

        for (int r = 0; r < 5; r++) begin
            do_reset();
            m_cfg_skip = int'($urandom_range(0, 3));
            cfg_skip   = 4'(m_cfg_skip);
            start_cmd();
            step();
            nf = int'($urandom_range(2, 6));
            for (int f = 0; f < nf; f++)
                frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 10)), -1, -1);
        end

        // start while a frame is already in progress
        do_reset();
        cfg_skip = 4'd0; m_cfg_skip = 0;
        clken_pulses = 0;
        per_frame_vsync = 1'b1;
        repeat (3) step();
        start_cmd();
        for (int l = 0; l < 2; l++) begin
            per_frame_href = 1'b1; per_frame_clken = 1'b1;
            repeat (8) step();
            per_frame_href = 1'b0; per_frame_clken = 1'b0;
            repeat (2) step();
        end
        per_frame_vsync = 1'b0;
        repeat (4) step();
        chk("partial_clken", 32'(clken_pulses), 32'd0);
        frame(4, 8, -1, -1);
        chk("after_partial_fcnt", 32'(frame_cnt), 32'd1);

        // stop during the second line: frame completes, next one is dropped
        do_reset();
        start_cmd();
        frame(4, 8, 1, -1);
        chk("stop_state", 32'(state), 32'd0);
        frame(4, 8, -1, -1);
        chk("stop_fcnt", 32'(frame_cnt), 32'd1);

        // simultaneous start and stop in IDLE
        do_reset();
        cmd_start = 1'b1; cmd_stop = 1'b1;
        step();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        chk("start_stop_state", 32'(state), 32'd0);

        // reset during line 3 of an active frame
        do_reset();
        start_cmd();
        frame(4, 8, -1, 2);

`ifdef CSC_SCHED_WINDOW_EN
        do_reset();
        cfg_x_start = 12'd2; cfg_x_end = 12'd5; cfg_y_start = 12'd1; cfg_y_end = 12'd2;
        win_x0 = 2; win_x1 = 5; win_y0 = 1; win_y1 = 2;
        start_cmd();
        clken_pulses = 0;
        frame(4, 8, -1, -1);
        chk("win_clken_pulses", 32'(clken_pulses), 32'd8);
        chk("win_pix_cnt", 32'(pix_cnt), 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
